// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm-domain blocks: ramp FSM state codes and a
// counter-width helper that stays legal for a modulus of 1.
package pwm_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    // A modulus of 1 still needs a 1-bit counter so the port widths stay non-zero.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running modulo-PRESCALE divider: clr parks the count at 0, en advances it,
// and tick marks the last count of each interval while enabled.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = cnt_width(PRESCALE);
    localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    // Gated by en so a held or idle counter sitting on LAST (always true for PRESCALE=1) never ticks.
    assign tick = en && (count_reg == LAST);

endmodule

// File: rtl/pwm_ramp.sv
// Slew-rate-limited duty setpoint: accepts a target over valid/ready and walks
// duty toward it by STEP once per prescaler tick, pulsing done on arrival.
module pwm_ramp
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int PRESCALE = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tgt,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic             hold,
    output logic [WIDTH-1:0] duty,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] target_reg, duty_reg;
    logic             done_reg;
    logic             tick, accept, reach;
    logic [WIDTH-1:0] diff;

    pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy && !hold),
        .clr   (!busy),
        .tick  (tick)
    );

    assign accept = tgt_valid && (state_reg == ST_IDLE);

    // Subtraction order follows the direction, so the difference never underflows.
    always_comb begin
        diff = '0;
        case (state_reg)
            ST_UP:   diff = target_reg - duty_reg;
            ST_DOWN: diff = duty_reg - target_reg;
            default: diff = '0;
        endcase
    end

    assign reach = (diff <= STEP_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (tgt > duty_reg)      state_next = ST_UP;
                    else if (tgt < duty_reg) state_next = ST_DOWN;
                end
            end
            ST_UP, ST_DOWN: begin
                if (tick && reach) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != ST_IDLE);
        tgt_ready = (state_reg == ST_IDLE);
    end

    // Landing exactly on the target when within one step is what keeps duty from wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_reg <= '0;
            duty_reg   <= '0;
            done_reg   <= 1'b0;
        end else begin
            if (accept) target_reg <= tgt;
            if (tick) begin
                if (reach)                  duty_reg <= target_reg;
                else if (state_reg == ST_UP) duty_reg <= duty_reg + STEP_W;
                else                        duty_reg <= duty_reg - STEP_W;
            end
            done_reg <= (accept && (tgt == duty_reg)) || (tick && reach);
        end
    end

    assign duty = duty_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_pwm_ramp.sv
// Directed bench for pwm_ramp: main instance WIDTH=8 STEP=3 PRESCALE=4, plus a
// STEP=255 instance for the single-step saturation case.
module tb_pwm_ramp;

    localparam int PS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tgt = '0;
    logic       tgt_valid = 1'b0;
    logic       hold = 1'b0;
    logic       tgt_ready, busy, done;
    logic [7:0] duty;

    logic [7:0] tgt2 = '0;
    logic       tgt_valid2 = 1'b0;
    logic       tgt_ready2, busy2, done2;
    logic [7:0] duty2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_ramp #(.WIDTH(8), .STEP(3), .PRESCALE(PS)) dut (
        .clk(clk), .rst_n(rst_n), .tgt(tgt), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .hold(hold), .duty(duty), .busy(busy), .done(done)
    );

    pwm_ramp #(.WIDTH(8), .STEP(255), .PRESCALE(PS)) dut2 (
        .clk(clk), .rst_n(rst_n), .tgt(tgt2), .tgt_valid(tgt_valid2), .tgt_ready(tgt_ready2),
        .hold(1'b0), .duty(duty2), .busy(busy2), .done(done2)
    );

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] v, input string name);
        checks++;
        if (tgt_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept-ready: tgt_ready=%b expected 1", name, tgt_ready);
        end
        tgt = v;
        tgt_valid = 1'b1;
        tick1();
        tgt_valid = 1'b0;
        $display("accept %s tgt=%0d", name, v);
    endtask

    // Expects duty to step through seq[0..n-1] at PS-clock intervals starting from start.
    task automatic ramp_check(input logic [7:0] start, input logic [3:0][7:0] seq,
                              input int n, input string name);
        logic [7:0] prev;
        prev = start;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < PS - 1; c++) begin
                tick1();
                checks++;
                if (duty !== prev || busy !== 1'b1 || done !== 1'b0 || tgt_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s between-steps: duty=%0d busy=%b done=%b rdy=%b expected duty=%0d busy=1 done=0 rdy=0",
                             name, duty, busy, done, tgt_ready, prev);
                end
            end
            tick1();
            checks++;
            if (i == n - 1) begin
                if (duty !== seq[i] || done !== 1'b1 || busy !== 1'b0 || tgt_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s final-step: duty=%0d done=%b busy=%b rdy=%b expected duty=%0d done=1 busy=0 rdy=1",
                             name, duty, done, busy, tgt_ready, seq[i]);
                end
            end else if (duty !== seq[i] || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s step%0d: duty=%0d done=%b busy=%b expected duty=%0d done=0 busy=1",
                         name, i, duty, done, busy, seq[i]);
            end
            $display("%s step%0d duty=%0d", name, i, duty);
            prev = seq[i];
        end
        tick1();
        checks++;
        if (done !== 1'b0 || tgt_ready !== 1'b1 || duty !== prev) begin
            errors++;
            $display("FAIL %s after-done: done=%b rdy=%b duty=%0d expected done=0 rdy=1 duty=%0d",
                     name, done, tgt_ready, duty, prev);
        end
    endtask

    task automatic wait_done(input int budget, input logic [7:0] exp, input string name);
        int   n;
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            tick1();
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || duty !== exp) begin
            errors++;
            $display("FAIL %s long-ramp: done_seen=%b duty=%0d expected done_seen=1 duty=%0d", name, seen, duty, exp);
        end
        $display("%s reached duty=%0d after %0d cycles", name, duty, n);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (duty !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || tgt_ready !== 1'b1 ||
            duty2 !== 8'd0 || tgt_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL reset: duty=%0d busy=%b done=%b rdy=%b duty2=%0d rdy2=%b expected 0,0,0,1,0,1",
                     duty, busy, done, tgt_ready, duty2, tgt_ready2);
        end
        $display("reset duty=%0d rdy=%b", duty, tgt_ready);
        @(negedge clk);
        rst_n = 1'b1;
        tick1();
    endtask

    task automatic test_ramp_up();
        accept(8'd10, "up");
        ramp_check(8'd0, {8'd10, 8'd9, 8'd6, 8'd3}, 4, "up");
    endtask

    task automatic test_ramp_down_ignore();
        accept(8'd2, "down");
        fork
            ramp_check(8'd10, {8'd0, 8'd2, 8'd4, 8'd7}, 3, "down");
            begin
                tgt = 8'd200;
                tgt_valid = 1'b1;
                repeat (5) tick1();
                tgt_valid = 1'b0;
            end
        join
    endtask

    task automatic test_equal();
        accept(8'd2, "equal");
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || duty !== 8'd2 || tgt_ready !== 1'b1) begin
            errors++;
            $display("FAIL equal-pulse: done=%b busy=%b duty=%0d rdy=%b expected 1,0,2,1", done, busy, duty, tgt_ready);
        end
        tick1();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || duty !== 8'd2) begin
            errors++;
            $display("FAIL equal-after: done=%b busy=%b duty=%0d expected 0,0,2", done, busy, duty);
        end
        $display("equal duty=%0d", duty);
    endtask

    task automatic test_saturation();
        accept(8'd250, "to250");
        wait_done(1000, 8'd250, "to250");
        tick1();
        accept(8'd255, "sat");
        ramp_check(8'd250, {8'd0, 8'd0, 8'd255, 8'd253}, 2, "sat");
        repeat (6) tick1();
        checks++;
        if (duty !== 8'd255 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sat-stable: duty=%0d busy=%b expected 255,0", duty, busy);
        end
        tgt2 = 8'd255;
        tgt_valid2 = 1'b1;
        tick1();
        tgt_valid2 = 1'b0;
        repeat (PS - 1) tick1();
        checks++;
        if (duty2 !== 8'd0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL bigstep-pre: duty2=%0d busy2=%b expected 0,1", duty2, busy2);
        end
        tick1();
        checks++;
        if (duty2 !== 8'd255 || done2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL bigstep: duty2=%0d done2=%b busy2=%b expected 255,1,0", duty2, done2, busy2);
        end
        $display("bigstep duty2=%0d", duty2);
    endtask

    task automatic test_hold();
        accept(8'd0, "to0");
        wait_done(1000, 8'd0, "to0");
        tick1();
        accept(8'd10, "hold");
        repeat (2) tick1();
        hold = 1'b1;
        repeat (9) begin
            tick1();
            checks++;
            if (duty !== 8'd0 || busy !== 1'b1 || tgt_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold-frozen: duty=%0d busy=%b rdy=%b expected 0,1,0", duty, busy, tgt_ready);
            end
        end
        hold = 1'b0;
        tick1();
        checks++;
        if (duty !== 8'd0) begin
            errors++;
            $display("FAIL hold-resume-pre: duty=%0d expected 0", duty);
        end
        tick1();
        checks++;
        if (duty !== 8'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold-resume: duty=%0d busy=%b expected 3,1", duty, busy);
        end
        $display("hold first step duty=%0d", duty);
        ramp_check(8'd3, {8'd0, 8'd10, 8'd9, 8'd6}, 3, "hold");
    endtask

    task automatic test_reset_mid_ramp();
        accept(8'd0, "to0b");
        wait_done(100, 8'd0, "to0b");
        tick1();
        accept(8'd10, "rst");
        repeat (2 * PS) tick1();
        checks++;
        if (duty !== 8'd6) begin
            errors++;
            $display("FAIL rst-pre: duty=%0d expected 6", duty);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (duty !== 8'd0 || busy !== 1'b0 || tgt_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst-async: duty=%0d busy=%b rdy=%b done=%b expected 0,0,1,0", duty, busy, tgt_ready, done);
        end
        $display("mid-ramp reset duty=%0d", duty);
        @(negedge clk);
        rst_n = 1'b1;
        tick1();
        accept(8'd3, "after-rst");
        ramp_check(8'd0, {8'd0, 8'd0, 8'd0, 8'd3}, 1, "after-rst");
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down_ignore();
        test_equal();
        test_saturation();
        test_hold();
        test_reset_mid_ramp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
